// File: rtl/dpwm_duty_sequencer.sv
// Duty-command sequencer for the dithered DPWM: clamps commands, applies them on period ticks,
// and ramps start-up/shut-down when built with SOFTSTART_EN (abrupt on/off otherwise).
module dpwm_duty_sequencer #(
  parameter int              DW      = 9,
  parameter int              PERIOD  = 64,
  parameter logic [DW-1:0]   DMIN    = 9'd8,
  parameter logic [DW-1:0]   DMAX    = 9'd460,
  parameter logic [DW-1:0]   SS_STEP = 9'd4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cmd_valid,
  input  logic [DW-1:0] cmd_duty,
  output logic          cmd_ready,
  output logic [DW-1:0] ditherin,
  output logic          period_tick,
  output logic          ss_done,
  output logic [1:0]    state
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOFTSTART = 2'd1,
    RUN       = 2'd2,
    SHUTDOWN  = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] tgt;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] clamped;
  logic          pend;
  logic          accept;

  if (DMIN > DMAX || SS_STEP == '0) begin : g_bad_params
    $error("dpwm_duty_sequencer: DMIN must not exceed DMAX and SS_STEP must be nonzero");
  end

  assign period_tick = (pcnt == PLAST);
  assign cmd_ready   = !pend && (state_q != SHUTDOWN);
  assign accept      = cmd_valid && cmd_ready;
  assign clamped     = (cmd_duty < DMIN) ? DMIN : ((cmd_duty > DMAX) ? DMAX : cmd_duty);
  assign state       = state_q;
  assign ditherin    = duty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else if (period_tick) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
  end

  // pend limits acceptance to one command per period; a same-edge accept beats the tick clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt  <= DMIN;
      pend <= 1'b0;
    end else if (accept) begin
      tgt  <= clamped;
      pend <= 1'b1;
    end else if (period_tick) begin
      pend <= 1'b0;
    end
  end

`ifdef SOFTSTART_EN
  logic [DW:0]   ramp_sum;
  logic [DW:0]   ramp_diff;
  logic [DW-1:0] ramp_up;
  logic [DW-1:0] ramp_dn;

  assign ramp_sum  = {1'b0, duty_q} + {1'b0, SS_STEP};
  assign ramp_diff = {1'b0, duty_q} - {1'b0, SS_STEP};
  assign ramp_up   = (ramp_sum >= {1'b0, tgt}) ? tgt : ramp_sum[DW-1:0];
  assign ramp_dn   = ramp_diff[DW] ? '0 : ramp_diff[DW-1:0];
`endif

  // state follows en on any edge; the applied duty only moves on tick edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      ss_done <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (period_tick) duty_q <= '0;
`ifdef SOFTSTART_EN
          if (en) state_q <= SOFTSTART;
`else
          if (en) begin
            state_q <= RUN;
            ss_done <= 1'b1;
          end
`endif
        end
`ifdef SOFTSTART_EN
        SOFTSTART: begin
          if (period_tick) duty_q <= ramp_up;
          if (!en) state_q <= SHUTDOWN;
          else if (period_tick && ramp_up == tgt) begin
            state_q <= RUN;
            ss_done <= 1'b1;
          end
        end
`endif
        RUN: begin
          if (period_tick) duty_q <= tgt;
          if (!en) begin
            state_q <= SHUTDOWN;
            ss_done <= 1'b0;
          end
        end
        SHUTDOWN: begin
`ifdef SOFTSTART_EN
          if (period_tick) duty_q <= ramp_dn;
          if (en) state_q <= SOFTSTART;
          else if (period_tick && ramp_dn == '0) state_q <= IDLE;
`else
          if (period_tick) duty_q <= '0;
          if (en) begin
            state_q <= RUN;
            ss_done <= 1'b1;
          end else if (period_tick) begin
            state_q <= IDLE;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpwm_duty_sequencer.sv
// Scoreboard bench for dpwm_duty_sequencer: stimulus queues per-tick expectations, a negedge
// monitor pops and compares them after each period tick. Covers both SOFTSTART_EN builds.
module tb_dpwm_duty_sequencer;

  localparam int PERIOD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [8:0] cmd_duty = '0;
  logic       cmd_ready;
  logic [8:0] ditherin;
  logic       period_tick;
  logic       ss_done;
  logic [1:0] state;

  typedef struct {
    int tick;
    int din;
    int st;
    int sd;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   ticks = 0;
  bit   tick_pending = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  dpwm_duty_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(cmd_ready), .ditherin(ditherin), .period_tick(period_tick),
    .ss_done(ss_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // monitor: the tick edge is the posedge after a negedge that saw period_tick high
  always @(negedge clk) begin
    if (tick_pending) begin
      ticks++;
      while (sb_q.size() > 0 && sb_q[0].tick <= ticks) begin
        e = sb_q.pop_front();
        if (e.tick < ticks) begin
          checkOutput($sformatf("tick%0d_missed", e.tick), ticks, e.tick);
        end else begin
          checkOutput($sformatf("tick%0d_ditherin", e.tick), int'(ditherin), e.din);
          checkOutput($sformatf("tick%0d_state", e.tick), int'(state), e.st);
          checkOutput($sformatf("tick%0d_ss_done", e.tick), int'(ss_done), e.sd);
        end
      end
    end
    tick_pending = period_tick;
  end

  function automatic int curTick();
    return ticks + int'(tick_pending);
  endfunction

  task automatic expectTick(input int tick, input int din, input int st, input int sd);
    exp_t x;
    x.tick = tick; x.din = din; x.st = st; x.sd = sd;
    sb_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic e_en, input logic valid, input int duty);
    en = e_en;
    cmd_valid = valid;
    cmd_duty = 9'(duty);
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!tick_pending && n < 2 * PERIOD + 4);
    if (!tick_pending) checkOutput("tick_timeout", n, PERIOD);
  endtask

  task automatic sendMid(input int duty);
    step(5);
    applyStimulus(en, 1'b1, duty);
    step(1);
    applyStimulus(en, 1'b0, duty);
  endtask

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_ditherin", int'(ditherin), 0);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset_period_tick", int'(period_tick), 0);
    checkOutput("reset_ss_done", int'(ss_done), 0);
    #9 rst = 1'b0;

    for (int n = 1; n <= 3 * PERIOD; n++) begin
      step(1);
      checkOutput($sformatf("period_tick_c%0d", n), int'(period_tick), int'((n % PERIOD) == PERIOD - 1));
    end

    // preload tgt in IDLE
    checkOutput("idle_cmd_ready", int'(cmd_ready), 1);
    applyStimulus(1'b0, 1'b1, 100);
    step(1);
    applyStimulus(1'b0, 1'b0, 100);
    checkOutput("pend_blocks_ready", int'(cmd_ready), 0);
    expectTick(curTick() + 1, 0, 0, 0);
    waitTick();
    checkOutput("tick_clears_pend", int'(cmd_ready), 1);

    applyStimulus(1'b1, 1'b0, 0);
    step(1);
`ifdef SOFTSTART_EN
    checkOutput("ss_enter_state", int'(state), 1);
    checkOutput("ss_enter_ss_done", int'(ss_done), 0);
    for (int k = 1; k <= 25; k++)
      expectTick(curTick() + k, 4 * k, (k == 25) ? 2 : 1, int'(k == 25));
    repeat (25) waitTick();
`else
    checkOutput("direct_run_state", int'(state), 2);
    checkOutput("direct_run_ss_done", int'(ss_done), 1);
    expectTick(curTick() + 1, 100, 2, 1);
    waitTick();
`endif

    // clamp both ends
    sendMid(500);
    expectTick(curTick() + 1, 460, 2, 1);
    waitTick();
    sendMid(3);
    expectTick(curTick() + 1, 8, 2, 1);
    waitTick();

    // accept on the tick edge itself: old tgt this tick, new one next tick
    begin
      int n = 0;
      while (!period_tick && n < PERIOD + 2) begin
        step(1);
        n++;
      end
    end
    applyStimulus(1'b1, 1'b1, 50);
    expectTick(curTick() + 1, 8, 2, 1);
    expectTick(curTick() + 2, 50, 2, 1);
    step(1);
    applyStimulus(1'b1, 1'b0, 50);
    waitTick();

    // back-to-back commands: second waits for the next period
    step(3);
    applyStimulus(1'b1, 1'b1, 200);
    step(1);
    checkOutput("first_cmd_blocks", int'(cmd_ready), 0);
    applyStimulus(1'b1, 1'b1, 300);
    expectTick(curTick() + 1, 200, 2, 1);
    expectTick(curTick() + 2, 300, 2, 1);
    waitTick();
    checkOutput("ready_after_tick", int'(cmd_ready), 1);
    step(1);
    checkOutput("second_cmd_taken", int'(cmd_ready), 0);
    applyStimulus(1'b1, 1'b0, 0);
    waitTick();

`ifdef SOFTSTART_EN
    sendMid(100);
    expectTick(curTick() + 1, 100, 2, 1);
    waitTick();
    step(5);
    applyStimulus(1'b0, 1'b0, 0);
    step(1);
    checkOutput("shutdown_state", int'(state), 3);
    checkOutput("shutdown_ss_done", int'(ss_done), 0);
    checkOutput("shutdown_cmd_ready", int'(cmd_ready), 0);
    for (int k = 1; k <= 15; k++) expectTick(curTick() + k, 100 - 4 * k, 3, 0);
    repeat (15) waitTick();
    step(5);
    applyStimulus(1'b1, 1'b0, 0);
    step(1);
    checkOutput("reenable_state", int'(state), 1);
    for (int k = 1; k <= 15; k++)
      expectTick(curTick() + k, 40 + 4 * k, (k == 15) ? 2 : 1, int'(k == 15));
    repeat (15) waitTick();
`else
    step(5);
    applyStimulus(1'b0, 1'b0, 0);
    step(1);
    checkOutput("shutdown_state", int'(state), 3);
    checkOutput("shutdown_ss_done", int'(ss_done), 0);
    checkOutput("shutdown_cmd_ready", int'(cmd_ready), 0);
    expectTick(curTick() + 1, 0, 0, 0);
    waitTick();
    applyStimulus(1'b1, 1'b0, 0);
    step(1);
    checkOutput("rerun_state", int'(state), 2);
    expectTick(curTick() + 1, 300, 2, 1);
    waitTick();
`endif

    // asynchronous reset in the middle of a RUN period
    step(10);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ditherin", int'(ditherin), 0);
    checkOutput("async_rst_state", int'(state), 0);
    checkOutput("async_rst_ss_done", int'(ss_done), 0);
    checkOutput("async_rst_cmd_ready", int'(cmd_ready), 1);
    applyStimulus(1'b0, 1'b0, 0);
    #20 rst = 1'b0;
    step(1);
    applyStimulus(1'b1, 1'b0, 0);
    step(1);
`ifdef SOFTSTART_EN
    checkOutput("post_rst_state", int'(state), 1);
    expectTick(curTick() + 1, 4, 1, 0);
    expectTick(curTick() + 2, 8, 2, 1);
    repeat (2) waitTick();
    sendMid(100);
    expectTick(curTick() + 1, 100, 2, 1);
    waitTick();
    step(5);
    applyStimulus(1'b0, 1'b0, 0);
    step(1);
    for (int k = 1; k <= 25; k++)
      expectTick(curTick() + k, 100 - 4 * k, (k == 25) ? 0 : 3, 0);
    repeat (25) waitTick();
`else
    checkOutput("post_rst_state", int'(state), 2);
    expectTick(curTick() + 1, 8, 2, 1);
    waitTick();
`endif

    step(2);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dpwm_duty_sequencer.md
# dpwm_duty_sequencer

Duty-command sequencer for the dithered DPWM path. Sits between the compensator and the 9-bit dither DPWM input: accepts duty commands over a valid/ready handshake, clamps them, and applies them only at switching-period boundaries. It also sequences converter start-up and shut-down with a duty ramp, so the DPWM never sees a step from 0 to full duty.

## Interface
- `DW`, 9: duty command / DPWM input width.
- `PERIOD`, 64: clk cycles per switching period; must match the DPWM counter period.
- `DMIN`, 9'd8: minimum duty in RUN.
- `DMAX`, 9'd460: maximum duty.
- `SS_STEP`, 9'd4: duty LSBs added or removed per period while ramping.

Ports (clock and reset first):
- `clk`  in  1  system clock; the same clock that drives the DPWM counter.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  converter enable; level-sensitive, synchronous to `clk`.
- `cmd_valid`  in  1  duty command valid.
- `cmd_duty`  in  DW  requested duty.
- `cmd_ready`  out  1  sequencer can accept a command.
- `ditherin`  out  DW  duty applied to the dither DPWM.
- `period_tick`  out  1  one-clk pulse on the last cycle of each period.
- `ss_done`  out  1  high while in RUN.
- `state`  out  2  IDLE=0, SOFTSTART=1, RUN=2, SHUTDOWN=3.

## Operation
- **Period counter `pcnt`**
  - Counts 0..PERIOD-1, then wraps to 0.
  - Free-running in every state.
  - `period_tick` = (`pcnt` == PERIOD-1), combinational decode.
  - A "tick edge" is the clk edge on which `period_tick` is 1.
- **Target register `tgt`**
  - On an accept edge (`cmd_valid` & `cmd_ready`), `tgt` <= clamp(`cmd_duty`, DMIN, DMAX).
  - An accept also sets `pend`.
- **`pend` flag**
  - Cleared on every tick edge.
  - If an accept and a tick fall on the same edge, set wins.
- **`cmd_ready`** = !`pend` & (`state` != SHUTDOWN). At most one command is accepted per period.
- **`ditherin` update**
  - Changes only on tick edges.
  - Uses the `tgt` value held before that edge. A command accepted on a tick edge therefore takes effect at the following tick.
- **IDLE**
  - `ditherin` = 0.
  - Commands may be accepted, which preloads `tgt`.
  - `en`=1 → SOFTSTART.
- **SOFTSTART**
  - Each tick: `ditherin` <= min(`ditherin`+SS_STEP, `tgt`).
  - When the value written equals `tgt` → RUN on the same edge.
  - If `tgt` drops below the current `ditherin`, `ditherin` <= `tgt` → RUN.
  - `en`=0 → SHUTDOWN.
- **RUN**
  - Each tick: `ditherin` <= `tgt`.
  - `en`=0 → SHUTDOWN.
- **SHUTDOWN**
  - Each tick: `ditherin` <= max(`ditherin`-SS_STEP, 0), saturating.
  - When 0 is written → IDLE.
  - `en`=1 → SOFTSTART, ramping from the current `ditherin` (no reset to 0).
- **Transitions on `en`** take effect on any clk edge. Only `ditherin` is tick-gated.
- **Arithmetic:** ramp sums use DW+1 bits internally, then saturate to the DW range.

## Timing
- **Reset values:** `state`=IDLE, `ditherin`=0, `tgt`=DMIN, `pcnt`=0, `pend`=0, `cmd_ready`=1, `period_tick`=0, `ss_done`=0.
- **Reset mid-operation:** asynchronous reset forces all of the above immediately, regardless of phase.
- **Latency:** accept at edge E → `ditherin` updates on the first tick edge strictly after E. That is 1 to PERIOD cycles.
- **First tick:** `period_tick` first asserts PERIOD-1 cycles after reset release.
- **Ramp duration:** start-up from 0 to target T takes ceil(T/SS_STEP) ticks.
- **`ss_done`** rises on the same edge that `state` enters RUN.

## Configuration
- **`SOFTSTART_EN` defined:** ramped SOFTSTART and SHUTDOWN, as described above.
- **`SOFTSTART_EN` undefined:**
  - `en`=1 in IDLE → RUN directly; `ditherin` <= `tgt` at the next tick.
  - `en`=0 → SHUTDOWN; `ditherin` <= 0 at the next tick, and IDLE on that same edge.
  - State 1 is never entered. Ports are unchanged.

## Test plan
With PERIOD=64, DMIN=8, DMAX=460, SS_STEP=4:
- **Reset:** release reset → `ditherin`=0, `state`=0, `cmd_ready`=1; `period_tick` high at cycles 63, 127, 191.
- **Soft-start:** preload `cmd_duty`=100 in IDLE, then `en`=1 → `ditherin` steps 4, 8, …, 100 over 25 ticks; `state`=2 and `ss_done`=1 on the 25th tick.
- **Clamp:** in RUN, `cmd_duty`=500 → `ditherin`=460 at the next tick; `cmd_duty`=3 → `ditherin`=8.
- **One command per period:** `cmd_valid` held for 2 commands (200, 300) → 200 is accepted and `cmd_ready`=0 until the tick. At that tick `ditherin`=200 and 300 is accepted on the following edge; `ditherin`=300 one period later.
- **Shutdown and re-enable:**
  - `en`=0 at `ditherin`=100 → 96, 92, …, 0 over 25 ticks, then `state`=0.
  - A repeat run with `en`=1 re-asserted at `ditherin`=40 → ramps 44, 48, … up to `tgt`.
- **Reset mid-operation and build variant:**
  - `rst` pulse mid-RUN, mid-period → `ditherin`=0 and `state`=0 with no clk edge.
  - Built without `SOFTSTART_EN`: `en`=1 with `tgt`=100 → `ditherin`=100 at the first tick.
